// File: rtl/jsv_keycode_fifo.sv
// Avalon-MM keycode buffer: direct mode drives out_port from each write; FIFO mode queues keys to a valid/ready stream.
// Push-to-key_valid 1 clock, 1 pop/clock; key_ready low holds the head, writes to a full FIFO are dropped and flagged in ovf.
module jsv_keycode_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [DATA_W-1:0] out_port
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              ovf;
    logic              fifo_en;

    logic wr_stb, wr_data, wr_status, wr_ctrl, flush;
    logic empty, full, push_req, push, pop, drop;
    logic [7:0] count8;
    logic unused_ok;

    assign unused_ok = ^writedata;

    always_comb begin
        wr_stb    = chipselect & ~write_n;
        wr_data   = wr_stb && (address == 2'd0);
        wr_status = wr_stb && (address == 2'd1);
        wr_ctrl   = wr_stb && (address == 2'd2);
        flush     = wr_ctrl & writedata[1];
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        key_valid = fifo_en & ~empty;
        key_data  = mem[rd_ptr];
        pop       = key_valid & key_ready & ~flush;
        push_req  = wr_data & fifo_en;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = push_req & (~full | pop) & ~flush;
        drop      = push_req & full & ~pop & ~flush;
        count8    = 8'(count);
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(out_port);
            2'd1:    readdata = {16'b0, count8, 5'b0, ovf, full, empty};
            2'd2:    readdata = {31'b0, fifo_en};
            default: readdata = '0;
        endcase
    end

    // Storage is intentionally not reset; key_data is only meaningful with key_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            fifo_en  <= 1'b0;
            out_port <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (wr_data && !fifo_en) begin
                out_port <= writedata[DATA_W-1:0];
            end else if (pop) begin
                out_port <= key_data;
            end

            if (drop) begin
                ovf <= 1'b1;
            end else if (wr_status && writedata[2]) begin
                ovf <= 1'b0;
            end

            if (wr_ctrl) begin
                fifo_en <= writedata[0];
            end
        end
    end

endmodule

// File: tb/tb_jsv_keycode_fifo.sv
// Bench for jsv_keycode_fifo: queue-based reference model updated on clock edges, monitor compares on the falling edge.
module tb_jsv_keycode_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  key_data;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_en = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_out = '0;
    logic       m_wr, m_flush, m_pop;
    logic       exp_vld;

    jsv_keycode_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_out};
            2'd1:    return {16'b0, 8'(mq.size()), 5'b0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
            2'd2:    return {31'b0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: a queue of pending keys plus the visible registers.
    initial begin : model
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_en  = 1'b0;
                m_ovf = 1'b0;
                m_out = '0;
            end else begin
                m_wr    = chipselect && !write_n;
                m_flush = m_wr && address == 2'd2 && writedata[1];
                m_pop   = m_en && mq.size() != 0 && key_ready && !m_flush;
                if (m_pop) m_out = mq.pop_front();
                if (m_wr && address == 2'd0) begin
                    if (!m_en) m_out = writedata[7:0];
                    else if (mq.size() < DEPTH) mq.push_back(writedata[7:0]);
                    else m_ovf = 1'b1;
                end
                if (m_flush) mq.delete();
                if (m_wr && address == 2'd1 && writedata[2]) m_ovf = 1'b0;
                if (m_wr && address == 2'd2) m_en = writedata[0];
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            exp_vld = m_en && mq.size() != 0;
            chk("mon_key_valid", {31'b0, key_valid}, {31'b0, exp_vld});
            if (exp_vld) chk("mon_key_data", {24'b0, key_data}, {24'b0, mq[0]});
            chk("mon_out_port", {24'b0, out_port}, {24'b0, m_out});
            chk("mon_readdata", readdata, exp_rd(address));
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a; #1;
        chk(name, readdata, exp);
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    int rdy_pct;
    int r;
    logic [7:0] e;

    initial begin : stim
        #1;
        chk("reset_key_valid", {31'b0, key_valid}, 32'h0);
        chk("reset_out_port", {24'b0, out_port}, 32'h0);
        chk("reset_status", readdata, 32'h1);
        #11 reset_n = 1'b1;
        idle();

        // Direct mode
        bus_write(2'd0, 32'hFFFF_FF1A);
        rd_chk("direct_readback", 2'd0, 32'h1A);
        chk("direct_out_port", {24'b0, out_port}, 32'h1A);
        chk("direct_key_valid", {31'b0, key_valid}, 32'h0);
        rd_chk("direct_status", 2'd1, 32'h1);
        idle();

        // FIFO order
        bus_write(2'd2, 32'h1);
        for (int k = 0; k < 3; k++) bus_write(2'd0, 32'h04 + k);
        rd_chk("order_status", 2'd1, 32'h300);
        idle();
        key_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("order_key_data", {24'b0, key_data}, 32'h04 + k);
            idle();
        end
        key_ready = 1'b0;
        chk("order_out_port", {24'b0, out_port}, 32'h06);
        chk("order_drained", {31'b0, key_valid}, 32'h0);
        rd_chk("order_empty", 2'd1, 32'h1);
        idle();

        // Full and overflow
        for (int k = 0; k < 9; k++) bus_write(2'd0, 32'h30 + k);
        rd_chk("ovf_status", 2'd1, 32'h806);
        idle();
        bus_write(2'd1, 32'h4);
        rd_chk("ovf_cleared", 2'd1, 32'h802);
        idle();

        // Push into a full FIFO while the head pops
        key_ready = 1'b1;
        bus_write(2'd0, 32'h2C);
        key_ready = 1'b0;
        rd_chk("fullpp_status", 2'd1, 32'h802);
        rd_chk("fullpp_out_port", 2'd0, 32'h30);
        idle();
        key_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = (k < 7) ? 8'(8'h31 + k) : 8'h2C;
            chk("fullpp_drain", {24'b0, key_data}, {24'b0, e});
            idle();
        end
        key_ready = 1'b0;
        rd_chk("fullpp_empty", 2'd1, 32'h1);
        rd_chk("fullpp_last", 2'd0, 32'h2C);
        idle();

        // Flush while the consumer is ready
        for (int k = 0; k < 3; k++) bus_write(2'd0, 32'h41 + k);
        key_ready = 1'b1;
        bus_write(2'd2, 32'h3);
        key_ready = 1'b0;
        rd_chk("flush_status", 2'd1, 32'h1);
        chk("flush_key_valid", {31'b0, key_valid}, 32'h0);
        rd_chk("flush_out_port", 2'd0, 32'h2C);
        idle();
        rd_chk("flush_ctrl", 2'd2, 32'h1);
        idle();

        // Asynchronous reset between edges
        for (int k = 0; k < 3; k++) bus_write(2'd0, 32'h51 + k);
        address = 2'd1;
        #2 reset_n = 1'b0;
        #1;
        chk("areset_key_valid", {31'b0, key_valid}, 32'h0);
        chk("areset_out_port", {24'b0, out_port}, 32'h0);
        chk("areset_status", readdata, 32'h1);
        #3 reset_n = 1'b1;
        idle();
        rd_chk("areset_after_status", 2'd1, 32'h1);
        rd_chk("areset_after_ctrl", 2'd2, 32'h0);
        idle();

        // Randomized traffic
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) rdy_pct = int'($urandom_range(90, 10));
            key_ready  = (int'($urandom_range(99)) < rdy_pct);
            chipselect = ($urandom_range(3) != 0);
            write_n    = 1'($urandom_range(1));
            r          = int'($urandom_range(99));
            address    = (r < 60) ? 2'd0 : (r < 75) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
            writedata  = $urandom();
            if (address == 2'd2) writedata[1:0] = {($urandom_range(15) == 0), ($urandom_range(7) != 0)};
            idle();
        end
        chipselect = 1'b0; write_n = 1'b1; key_ready = 1'b0;
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
